// File: rtl/filter_output_packer_pkg.sv
// rtl/filter_output_packer_pkg.sv - word codes, widths and FSM states for the filter output packer
package FilterPackerPkg;

   localparam int WORD_W      = 32;
   localparam int FRAME_CNT_W = 16;

   localparam logic [1:0] CODE_HDR = 2'b11;
   localparam logic [1:0] CODE_W0  = 2'b01;
   localparam logic [1:0] CODE_W1  = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      WORD0  = 2'd2,
      WORD1  = 2'd3
   } pack_state_e;

endpackage

// File: rtl/filter_output_packer_if.sv
// rtl/filter_output_packer_if.sv - per-filter {filt, state} record channel from the filter array
interface FilterOutputChannel #(
   parameter int Nfilts = 10,
   parameter int Nstate = 27
);
   logic [Nfilts-1:0] filt;
   logic [Nstate-1:0] state;
   logic              v;
   logic              r;

   modport master   (output filt, output state, output v, input  r);
   modport slave    (input  filt, input  state, input  v, output r);
   modport producer (output filt, output state, output v, input  r);
   modport consumer (input  filt, input  state, input  v, output r);
endinterface

// File: rtl/filter_output_packer.sv
// rtl/filter_output_packer.sv - thresholds filter records and serializes them into 32-bit host words
module filter_output_packer
   import FilterPackerPkg::*;
#(
   parameter int Nfilts = 10,
   parameter int Nstate = 27
) (
   input  logic                clk,
   input  logic                reset,
   FilterOutputChannel.consumer in,
   input  logic                pack_en,
   input  logic [Nstate-1:0]   min_state,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_v,
   input  logic                out_r
);

   pack_state_e             fsm_q;
   logic [FRAME_CNT_W-1:0]  frame_cnt_q;
   logic [Nfilts-1:0]       filt_q;
   logic [Nstate-1:0]       state_q;
   logic                    keep_q;
   logic [WORD_W-1:0]       out_data_q;
   logic                    out_v_q;

   logic                    acc_hdr;
   logic                    acc_keep;

   function automatic logic [WORD_W-1:0] header_word(input logic [FRAME_CNT_W-1:0] cnt);
      return {CODE_HDR, 14'b0, cnt};
   endfunction

   // Upper state bits ride with the filter index; the low 10 bits go in WORD1.
   function automatic logic [WORD_W-1:0] word0_word(input logic [Nfilts-1:0] f,
                                                    input logic [Nstate-1:0] s);
      logic [WORD_W-3:0] payload;
      payload = (WORD_W-2)'({f, s[Nstate-1:10]});
      return {CODE_W0, payload};
   endfunction

   function automatic logic [WORD_W-1:0] word1_word(input logic [Nstate-1:0] s);
      return {CODE_W1, 20'b0, s[9:0]};
   endfunction

   assign acc_hdr  = (in.filt == '0);
   assign acc_keep = (in.state >= min_state);

   assign in.r     = (fsm_q == IDLE);
   assign out_data = out_data_q;
   assign out_v    = out_v_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q       <= IDLE;
         frame_cnt_q <= '0;
         filt_q      <= '0;
         state_q     <= '0;
         keep_q      <= 1'b0;
         out_data_q  <= '0;
         out_v_q     <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in.v) begin
                  filt_q  <= in.filt;
                  state_q <= in.state;
                  keep_q  <= acc_keep;
                  // With packing disabled the record is consumed and nothing else changes.
                  if (pack_en && acc_hdr) begin
                     fsm_q      <= HEADER;
                     out_v_q    <= 1'b1;
                     out_data_q <= header_word(frame_cnt_q);
                  end else if (pack_en && acc_keep) begin
                     fsm_q      <= WORD0;
                     out_v_q    <= 1'b1;
                     out_data_q <= word0_word(in.filt, in.state);
                  end
               end
            end
            HEADER: begin
               if (out_r) begin
                  frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                  if (keep_q) begin
                     fsm_q      <= WORD0;
                     out_data_q <= word0_word(filt_q, state_q);
                  end else begin
                     fsm_q      <= IDLE;
                     out_v_q    <= 1'b0;
                     out_data_q <= '0;
                  end
               end
            end
            WORD0: begin
               if (out_r) begin
                  fsm_q      <= WORD1;
                  out_data_q <= word1_word(state_q);
               end
            end
            WORD1: begin
               if (out_r) begin
                  fsm_q      <= IDLE;
                  out_v_q    <= 1'b0;
                  out_data_q <= '0;
               end
            end
            default: begin
               fsm_q   <= IDLE;
               out_v_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_filter_output_packer.sv
// tb/tb_filter_output_packer.sv - randomized scoreboard bench for filter_output_packer
module tb_filter_output_packer;
   import FilterPackerPkg::*;

   localparam int NF = 10;
   localparam int NS = 27;

   logic          clk = 1'b0;
   logic          reset;
   logic          pack_en;
   logic [NS-1:0] min_state;
   logic [31:0]   out_data;
   logic          out_v;
   logic          out_r;

   FilterOutputChannel #(.Nfilts(NF), .Nstate(NS)) bus ();

   filter_output_packer #(.Nfilts(NF), .Nstate(NS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (bus),
      .pack_en   (pack_en),
      .min_state (min_state),
      .out_data  (out_data),
      .out_v     (out_v),
      .out_r     (out_r)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [15:0] m_frame;
   bit          rand_ready = 1'b0;

   // Reference: a record turns into an optional header plus an optional data word pair.
   function automatic void model_accept(input logic [NF-1:0] f, input logic [NS-1:0] s,
                                        input logic en, input logic [NS-1:0] mn);
      if (!en) return;
      if (f == 0) begin
         exp_q.push_back(32'hC000_0000 + 32'(m_frame));
         m_frame = m_frame + 16'd1;
      end
      if (s >= mn) begin
         exp_q.push_back(32'h4000_0000 | (32'(f) << (NS - 10)) | (32'(s) >> 10));
         exp_q.push_back(32'h8000_0000 | (32'(s) & 32'h3FF));
      end
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (out_v && out_r) got_q.push_back(out_data);
         if (bus.v && bus.r) model_accept(bus.filt, bus.state, pack_en, min_state);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_r = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.v = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      m_frame = 16'd0;
   endtask

   task automatic send_record(input logic [NF-1:0] f, input logic [NS-1:0] s);
      bit acc;
      acc = 1'b0;
      @(posedge clk);
      #1;
      bus.v = 1'b1;
      bus.filt = f;
      bus.state = s;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (bus.r) begin
            acc = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.v = 1'b0;
      if (!acc) begin
         checks++;
         $display("FAIL send_record: in.r never rose for filt %0d", f);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #2;
         if (!out_v && bus.r && !bus.v && got_q.size() == exp_q.size()) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.v = 1'b0;
      bus.filt = '0;
      bus.state = '0;
      pack_en = 1'b1;
      min_state = '0;
      out_r = 1'b1;
      m_frame = 16'd0;
      repeat (2) @(negedge clk);
      checks++; if (out_v !== 1'b0) $display("FAIL reset_out_v: got %b want 0", out_v); else passed++;
      checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
      checks++; if (bus.r !== 1'b1) $display("FAIL reset_in_r: got %b want 1", bus.r); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_single_record();
      logic [31:0] want [3];
      want[0] = 32'hC000_0000;
      want[1] = 32'h4000_0004;
      want[2] = 32'h8000_0234;
      pack_en = 1'b1;
      min_state = '0;
      out_r = 1'b1;
      @(posedge clk);
      #1;
      bus.v = 1'b1;
      bus.filt = '0;
      bus.state = 27'h0001234;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         bus.v = 1'b0;
         checks++;
         if ({out_v, bus.r, out_data} !== {2'b10, want[i]})
            $display("FAIL single_word%0d: got v=%b r=%b %h want v=1 r=0 %h", i, out_v, bus.r, out_data, want[i]);
         else passed++;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_v, bus.r} !== 2'b01) $display("FAIL single_done: got v=%b r=%b want v=0 r=1", out_v, bus.r);
      else passed++;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_sweep();
      bit ok;
      logic [NS-1:0] st [4];
      st[0] = 27'd5; st[1] = 27'd0; st[2] = 27'd7; st[3] = 27'd0;
      apply_reset();
      pack_en = 1'b1;
      min_state = 27'd1;
      out_r = 1'b1;
      for (int i = 0; i < 4; i++) send_record(NF'(i), st[i]);
      send_record('0, 27'd9);
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL sweep_drain: timed out got %0d want %0d words", got_q.size(), exp_q.size()); else passed++;
      checks++; if (got_q.size() != 8) $display("FAIL sweep_count: got %0d want 8 words", got_q.size()); else passed++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL sweep_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
      if (got_q.size() > 5) begin
         checks++;
         if (got_q[5] !== 32'hC000_0001) $display("FAIL sweep_hdr1: got %h want c0000001", got_q[5]);
         else passed++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [NF-1:0] f;
      logic [NS-1:0] s;
      logic [31:0]   w0, w1;
      f = 10'h2A;
      s = NS'($urandom);
      w0 = 32'h4000_0000 | (32'(f) << (NS - 10)) | (32'(s) >> 10);
      w1 = 32'h8000_0000 | (32'(s) & 32'h3FF);
      pack_en = 1'b1;
      min_state = '0;
      out_r = 1'b0;
      @(posedge clk);
      #1;
      bus.v = 1'b1;
      bus.filt = f;
      bus.state = s;
      @(posedge clk);
      #1;
      bus.v = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_v, bus.r, out_data} !== {2'b10, w0})
            $display("FAIL bp_hold%0d: got v=%b r=%b %h want v=1 r=0 %h", i, out_v, bus.r, out_data, w0);
         else passed++;
         if (i < 4) begin
            @(posedge clk);
            #1;
         end
      end
      out_r = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_v, bus.r, out_data} !== {2'b10, w1}) $display("FAIL bp_word1: got v=%b %h want v=1 %h", out_v, out_data, w1);
      else passed++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL bp_drain: timed out"); else passed++;
      checks++; if (got_q.size() != 2) $display("FAIL bp_count: got %0d want 2 words", got_q.size()); else passed++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_pack_disabled();
      bit ok;
      logic [15:0] saved;
      saved = m_frame;
      pack_en = 1'b0;
      min_state = '0;
      out_r = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus.v = 1'b1;
         bus.filt = NF'(i);
         bus.state = NS'($urandom);
         checks++;
         if ({out_v, bus.r} !== 2'b01) $display("FAIL off_cycle%0d: got v=%b r=%b want v=0 r=1", i, out_v, bus.r);
         else passed++;
      end
      @(posedge clk);
      #1;
      bus.v = 1'b0;
      checks++;
      if ({out_v, bus.r} !== 2'b01) $display("FAIL off_tail: got v=%b r=%b want v=0 r=1", out_v, bus.r);
      else passed++;
      pack_en = 1'b1;
      send_record('0, 27'h7FFFFFF);
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL off_drain: timed out"); else passed++;
      checks++;
      if (got_q.size() != 3 || got_q[0] !== (32'hC000_0000 | 32'(saved)))
         $display("FAIL off_next_hdr: got %0d words first %h want 3 words first %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0, 32'hC000_0000 | 32'(saved));
      else passed++;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      bit ok;
      logic [NF-1:0] f;
      logic [NS-1:0] s;
      rand_ready = 1'b1;
      for (int n = 0; n < 150; n++) begin
         pack_en = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 2))
            0: min_state = '0;
            1: min_state = NS'($urandom);
            default: min_state = NS'($urandom_range(0, 2047));
         endcase
         f = ($urandom_range(0, 3) == 0) ? '0 : NF'($urandom_range(1, 1023));
         s = ($urandom_range(0, 1) == 0) ? NS'($urandom) : NS'($urandom_range(0, 4095));
         send_record(f, s);
      end
      rand_ready = 1'b0;
      out_r = 1'b1;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL rand_drain: timed out got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
      checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_wrap();
      bit ok;
      wait_idle(ok);
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      m_frame = 16'hFFFF;
      pack_en = 1'b1;
      min_state = 27'd1;
      out_r = 1'b1;
      send_record('0, '0);
      send_record('0, '0);
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL wrap_drain: timed out"); else passed++;
      checks++;
      if (got_q.size() != 2 || got_q[0] !== 32'hC000_FFFF || got_q[1] !== 32'hC000_0000)
         $display("FAIL wrap_headers: got %0d words %h %h want c000ffff c0000000", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 32'h0, (got_q.size() > 1) ? got_q[1] : 32'h0);
      else passed++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL wrap_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid_record();
      bit ok;
      pack_en = 1'b1;
      min_state = '0;
      out_r = 1'b0;
      send_record(10'd7, NS'($urandom));
      checks++;
      if (out_v !== 1'b1) $display("FAIL mid_word0_held: got v=%b want 1", out_v); else passed++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({out_v, bus.r, out_data} !== {2'b01, 32'h0})
         $display("FAIL mid_reset_out: got v=%b r=%b %h want v=0 r=1 0", out_v, bus.r, out_data);
      else passed++;
      @(posedge clk);
      got_q.delete();
      exp_q.delete();
      m_frame = 16'd0;
      #1;
      reset = 1'b0;
      out_r = 1'b1;
      bus.v = 1'b1;
      bus.filt = '0;
      bus.state = 27'h55;
      @(posedge clk);
      #1;
      bus.v = 1'b0;
      checks++;
      if ({out_v, out_data} !== {1'b1, 32'hC000_0000})
         $display("FAIL mid_first_hdr: got v=%b %h want v=1 c0000000", out_v, out_data);
      else passed++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL mid_drain: timed out"); else passed++;
      checks++; if (got_q.size() != 3) $display("FAIL mid_count: got %0d want 3 words", got_q.size()); else passed++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL mid_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_single_record();
      test_sweep();
      test_backpressure();
      test_pack_disabled();
      test_random();
      test_wrap();
      test_reset_mid_record();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
